// File: rtl/mem_entry_loader_pkg.sv
// Shared constants for the memory entry loader: FSM state encoding and parameter defaults.
package mem_entry_loader_pkg;

  localparam int unsigned WIDTH_DEF   = 16;
  localparam int unsigned AW_DEF      = 8;
  localparam int unsigned TIMEOUT_DEF = 15;
  localparam int unsigned STATE_W     = 2;

  typedef logic [STATE_W-1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t REQ  = 2'd1;
  localparam state_t DONE = 2'd2;

  // Bits needed to hold 0..max_val.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/mem_entry_loader_wait_timer.sv
// Clearable wait counter with a terminal-count flag at TIMEOUT.
module wait_timer
  import mem_entry_loader_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic terminal_c
);

  localparam int unsigned CW = cnt_width(TIMEOUT);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         count <= '0;
    else if (clear)  count <= '0;
    else if (enable) count <= count + CW'(1);
  end

  assign terminal_c = (count == CW'(TIMEOUT));

endmodule

// File: rtl/mem_entry_loader.sv
// Loads operator switch values into memory one word at a time via a req/ack write port.
module mem_entry_loader
  import mem_entry_loader_pkg::*;
#(
  parameter int unsigned WIDTH   = WIDTH_DEF,
  parameter int unsigned AW      = AW_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             LoadAddr,
  input  logic             LoadData,
  input  logic [WIDTH-1:0] Sw,
  input  logic             WrAck,
  output logic             WrReq,
  output logic [AW-1:0]    WrAddr,
  output logic [WIDTH-1:0] WrData,
  output logic [AW-1:0]    Addr,
  output logic [AW-1:0]    Count,
  output logic             Busy,
  output logic             Error
);

  state_t state;
  state_t state_nxt;
  logic   timeout_c;
  logic   strobe_drop;
  logic   timeout_hit;

  wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
    .clk        (Clock),
    .rst        (Reset),
    .clear      (state != REQ),
    .enable     ((state == REQ) && !WrAck),
    .terminal_c (timeout_c)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Ack wins over timeout when both land on the same cycle.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (LoadData && !LoadAddr) state_nxt = REQ;
      REQ: begin
        if (WrAck)          state_nxt = DONE;
        else if (timeout_c) state_nxt = IDLE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign WrReq = (state == REQ);
  assign Busy  = (state != IDLE);

  assign strobe_drop = (state != IDLE) && (LoadAddr || LoadData);
  assign timeout_hit = (state == REQ) && !WrAck && timeout_c;

  // Address pointer, write latches, write counter and sticky error.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      Addr   <= '0;
      Count  <= '0;
      WrAddr <= '0;
      WrData <= '0;
      Error  <= 1'b0;
    end else begin
      if (state == IDLE) begin
        if (LoadAddr) begin
          Addr <= Sw[AW-1:0];
        end else if (LoadData) begin
          WrAddr <= Addr;
          WrData <= Sw;
        end
      end
      if (state == DONE) begin
        Addr <= Addr + AW'(1);
        if (Count != '1) Count <= Count + AW'(1);
      end
      if (strobe_drop || timeout_hit) Error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_entry_loader.sv
// Self-checking bench for mem_entry_loader: vector table plus hand-written corner sequences.
`timescale 1ns/1ps
module tb_mem_entry_loader;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned AW    = 8;
  localparam int unsigned TO    = 15;

  logic             Clock = 1'b0;
  logic             Reset;
  logic             LoadAddr;
  logic             LoadData;
  logic [WIDTH-1:0] Sw;
  logic             WrAck;
  logic             WrReq;
  logic [AW-1:0]    WrAddr;
  logic [WIDTH-1:0] WrData;
  logic [AW-1:0]    Addr;
  logic [AW-1:0]    Count;
  logic             Busy;
  logic             Error;

  mem_entry_loader #(.WIDTH(WIDTH), .AW(AW), .TIMEOUT(TO)) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .LoadAddr (LoadAddr),
    .LoadData (LoadData),
    .Sw       (Sw),
    .WrAck    (WrAck),
    .WrReq    (WrReq),
    .WrAddr   (WrAddr),
    .WrData   (WrData),
    .Addr     (Addr),
    .Count    (Count),
    .Busy     (Busy),
    .Error    (Error)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] data;
  } wr_t;

  typedef struct {
    logic             la;
    logic [AW-1:0]    a;
    logic [WIDTH-1:0] d;
    int               ack;
    logic [AW-1:0]    exp_addr;
    logic [AW-1:0]    exp_count;
  } vec_t;

  wr_t exp_q[$];
  int  pass_cnt  = 0;
  int  total_cnt = 0;

  logic [AW-1:0] m_addr;
  logic [AW-1:0] m_count;
  logic          m_err;
  logic          prev_req = 1'b0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  // Scoreboard: the write presented while WrReq is high must match the queued expectation.
  always @(negedge Clock) begin
    if (WrReq) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_wrreq: got WrReq=1 expected no pending write");
      end else begin
        check("sb_wr_addr", 32'(WrAddr), 32'(exp_q[0].addr));
        check("sb_wr_data", 32'(WrData), 32'(exp_q[0].data));
      end
    end
    if (prev_req && !WrReq && exp_q.size() > 0) void'(exp_q.pop_front());
    prev_req = WrReq;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_wrreq"},  32'(WrReq),  0);
    check({tag, "_busy"},   32'(Busy),   0);
    check({tag, "_error"},  32'(Error),  0);
    check({tag, "_addr"},   32'(Addr),   0);
    check({tag, "_count"},  32'(Count),  0);
    check({tag, "_wraddr"}, 32'(WrAddr), 0);
    check({tag, "_wrdata"}, 32'(WrData), 0);
  endtask

  task automatic apply_reset();
    Reset = 1'b1;
    #1;
    check_reset_vals("reset");
    step();
    Reset = 1'b0;
    exp_q.delete();
    m_addr = '0; m_count = '0; m_err = 1'b0;
  endtask

  task automatic load_addr(input logic [AW-1:0] a);
    Sw = WIDTH'(a); LoadAddr = 1'b1;
    step();
    LoadAddr = 1'b0;
    m_addr = a;
    check("load_addr", 32'(Addr), 32'(a));
    check("load_addr_nobus", 32'(WrReq), 0);
  endtask

  // ack_at: REQ cycle (1-based) on which WrAck is high; 0 means never acknowledge.
  task automatic do_write(input logic [WIDTH-1:0] d, input int ack_at, input string tag);
    int n;
    exp_q.push_back('{addr: m_addr, data: d});
    Sw = d; LoadData = 1'b1;
    step();
    LoadData = 1'b0;
    check({tag, "_req_rise"}, 32'(WrReq), 1);
    n = 0;
    while (WrReq && n < 40) begin
      n++;
      if (n == ack_at) WrAck = 1'b1;
      step();
      WrAck = 1'b0;
    end
    if (ack_at > 0) begin
      check({tag, "_req_cycles"}, 32'(n), 32'(ack_at));
      check({tag, "_done_busy"}, 32'(Busy), 1);
      step();
      m_addr = m_addr + AW'(1);
      if (m_count != '1) m_count = m_count + AW'(1);
    end else begin
      check({tag, "_timeout_cycles"}, 32'(n), TO + 1);
      m_err = 1'b1;
    end
    check({tag, "_addr"},  32'(Addr),  32'(m_addr));
    check({tag, "_count"}, 32'(Count), 32'(m_count));
    check({tag, "_error"}, 32'(Error), 32'(m_err));
    check({tag, "_idle"},  32'(Busy),  0);
  endtask

  initial begin
    vec_t vecs[4];
    vecs[0] = '{la: 1'b1, a: 8'h12, d: 16'hBEEF, ack: 3, exp_addr: 8'h13, exp_count: 8'd1};
    vecs[1] = '{la: 1'b0, a: 8'h00, d: 16'h1234, ack: 1, exp_addr: 8'h14, exp_count: 8'd2};
    vecs[2] = '{la: 1'b1, a: 8'hFF, d: 16'hA5A5, ack: 2, exp_addr: 8'h00, exp_count: 8'd3};
    vecs[3] = '{la: 1'b0, a: 8'h00, d: 16'h0F0F, ack: 5, exp_addr: 8'h01, exp_count: 8'd4};

    Reset = 1'b1; LoadAddr = 1'b0; LoadData = 1'b0; Sw = '0; WrAck = 1'b0;
    apply_reset();

    for (int i = 0; i < 4; i++) begin
      if (vecs[i].la) load_addr(vecs[i].a);
      do_write(vecs[i].d, vecs[i].ack, $sformatf("vec%0d", i));
      check($sformatf("vec%0d_tbl_addr", i),  32'(Addr),  32'(vecs[i].exp_addr));
      check($sformatf("vec%0d_tbl_count", i), 32'(Count), 32'(vecs[i].exp_count));
    end

    // Simultaneous strobes: address load wins, no write, no error.
    Sw = 16'h0040; LoadAddr = 1'b1; LoadData = 1'b1;
    step();
    LoadAddr = 1'b0; LoadData = 1'b0;
    check("collide_addr",  32'(Addr),  32'h40);
    check("collide_wrreq", 32'(WrReq), 0);
    check("collide_busy",  32'(Busy),  0);
    check("collide_error", 32'(Error), 0);
    m_addr = 8'h40;
    step();
    check("collide_still_idle", 32'(WrReq), 0);

    // Strobe arriving mid-REQ is dropped and flags an error; one write only.
    apply_reset();
    load_addr(8'h20);
    exp_q.push_back('{addr: 8'h20, data: 16'hCAFE});
    Sw = 16'hCAFE; LoadData = 1'b1;
    step();
    Sw = 16'h5555;
    step();
    LoadData = 1'b0;
    check("drop_error", 32'(Error), 1);
    check("drop_wrreq", 32'(WrReq), 1);
    WrAck = 1'b1;
    step();
    WrAck = 1'b0;
    step();
    repeat (3) step();
    check("drop_addr",  32'(Addr),  32'h21);
    check("drop_count", 32'(Count), 1);
    check("drop_idle",  32'(Busy),  0);

    // Timeout leaves pointer and count alone and sets the sticky error.
    apply_reset();
    load_addr(8'h30);
    do_write(16'h0077, 0, "tmo");
    repeat (2) step();
    check("tmo_error_sticky", 32'(Error), 1);

    // Reset mid-REQ drops WrReq asynchronously; no increment follows.
    apply_reset();
    load_addr(8'h50);
    exp_q.push_back('{addr: 8'h50, data: 16'h9999});
    Sw = 16'h9999; LoadData = 1'b1;
    step();
    LoadData = 1'b0;
    step();
    check("rst_mid_pre_wrreq", 32'(WrReq), 1);
    #3;
    Reset = 1'b1;
    #1;
    check_reset_vals("rst_mid");
    WrAck = 1'b1;
    step();
    WrAck = 1'b0;
    step();
    check("rst_mid_no_inc_addr",  32'(Addr),  0);
    check("rst_mid_no_inc_count", 32'(Count), 0);
    Reset = 1'b0;
    exp_q.delete();
    Sw = 16'h0033; LoadAddr = 1'b1;
    step();
    LoadAddr = 1'b0;
    check("post_rst_first_edge", 32'(Addr), 32'h33);

    step();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
